// File: rtl/sound_arbiter_pkg.sv
// sound_arbiter_pkg: source indices, one-hot grant codes, FSM states and helpers shared by the sound arbiter and its users
package sound_arbiter_pkg;
  localparam int SRC_WALL = 0;
  localparam int SRC_HIT = 1;
  localparam int SRC_POINT = 2;
  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_WALL = 3'b001;
  localparam logic [2:0] GNT_HIT = 3'b010;
  localparam logic [2:0] GNT_POINT = 3'b100;
  typedef enum logic {IDLE, PLAY} state_t;
  function automatic logic [2:0] prio_pick(input logic [2:0] r);
    return r[SRC_POINT] ? GNT_POINT : r[SRC_HIT] ? GNT_HIT : r[SRC_WALL] ? GNT_WALL : GNT_NONE;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// tone_gen: square-wave generator with half-period, ms-tick and duration counters
module tone_gen #(
  parameter int HW = 16,
  parameter int TW = 15,
  parameter int MW = 8,
  parameter int TICK_DIV = 31500
) (
  input  logic          clk32mhz,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [HW-1:0] hp_max,
  input  logic [MW-1:0] dur,
  output logic          buzzer,
  output logic          done
);
  logic [HW-1:0] hp_cnt;
  logic [TW-1:0] tick_cnt;
  logic [MW-1:0] ms_cnt;
  logic hp_wrap, tick_wrap;
  assign hp_wrap = hp_cnt == hp_max;
  assign tick_wrap = tick_cnt == TW'(TICK_DIV - 1);
  assign done = en && tick_wrap && ms_cnt == dur - MW'(1);
  always_ff @(posedge clk32mhz) begin
    if (reset || (!load && (!en || done))) begin
      hp_cnt <= '0;
      tick_cnt <= '0;
      ms_cnt <= '0;
      buzzer <= 1'b0;
    end else if (load) begin
      hp_cnt <= '0;
      tick_cnt <= '0;
      ms_cnt <= '0;
      buzzer <= 1'b1;
    end else begin
      hp_cnt <= hp_wrap ? '0 : hp_cnt + HW'(1);
      buzzer <= hp_wrap ? ~buzzer : buzzer;
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
      ms_cnt <= tick_wrap ? ms_cnt + MW'(1) : ms_cnt;
    end
  end
endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: fixed-priority buzzer arbiter for point/hit/wall sounds with preemption, queuing and mute
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int TICK_DIV = 31500,
  parameter int HP_POINT = 63000,
  parameter int HP_HIT = 31500,
  parameter int HP_WALL = 15750,
  parameter int DUR_POINT = 250,
  parameter int DUR_HIT = 40,
  parameter int DUR_WALL = 20
) (
  input  logic       clk32mhz,
  input  logic       reset,
  input  logic       evt_point,
  input  logic       evt_hit,
  input  logic       evt_wall,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] grant
);
  localparam int HW = $clog2(max3(HP_POINT, HP_HIT, HP_WALL));
  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = $clog2(max3(DUR_POINT, DUR_HIT, DUR_WALL) + 1);
  state_t state;
  logic [2:0] pend, req, pick;
  logic load, done;
  logic [HW-1:0] hp_max;
  logic [MW-1:0] dur;
  assign req = pend | {evt_point, evt_hit, evt_wall};
  assign pick = prio_pick(req);
  assign load = !mute && (state == IDLE ? |req : pick > grant);
  always_comb begin
    hp_max = grant[SRC_POINT] ? HW'(HP_POINT - 1) : grant[SRC_HIT] ? HW'(HP_HIT - 1) : HW'(HP_WALL - 1);
    dur = grant[SRC_POINT] ? MW'(DUR_POINT) : grant[SRC_HIT] ? MW'(DUR_HIT) : MW'(DUR_WALL);
  end
  always_ff @(posedge clk32mhz) begin
    if (reset || mute) begin
      state <= IDLE;
      pend <= '0;
      busy <= 1'b0;
      grant <= GNT_NONE;
    end else if (load) begin
      state <= PLAY;
      pend <= req & ~pick;
      busy <= 1'b1;
      grant <= pick;
    end else if (state == PLAY && done) begin
      state <= IDLE;
      pend <= req;
      busy <= 1'b0;
      grant <= GNT_NONE;
    end else begin
      pend <= req;
    end
  end
  tone_gen #(
    .HW(HW),
    .TW(TW),
    .MW(MW),
    .TICK_DIV(TICK_DIV)
  ) u_tone (
    .clk32mhz(clk32mhz),
    .reset(reset),
    .load(load),
    .en(state == PLAY && !mute),
    .hp_max(hp_max),
    .dur(dur),
    .buzzer(buzzer),
    .done(done)
  );
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed and random stimulus against a tone-timeline reference model
module tb_sound_arbiter;
  import sound_arbiter_pkg::*;
  localparam int TD = 10;
  int hp[3];
  int dur[3];
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic evt_point = 1'b0, evt_hit = 1'b0, evt_wall = 1'b0, mute = 1'b0;
  logic buzzer, busy;
  logic [2:0] grant;
  int n_run = 0, n_fail = 0;
  int cur = -1, el = 0, busy_cnt = 0, mute_left = 0;
  logic [2:0] pend_m = 3'b000;
  sound_arbiter #(
    .TICK_DIV(TD),
    .HP_POINT(4),
    .HP_HIT(3),
    .HP_WALL(2),
    .DUR_POINT(3),
    .DUR_HIT(2),
    .DUR_WALL(1)
  ) dut (
    .clk32mhz(clk),
    .reset(reset),
    .evt_point(evt_point),
    .evt_hit(evt_hit),
    .evt_wall(evt_wall),
    .mute(mute),
    .buzzer(buzzer),
    .busy(busy),
    .grant(grant)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model(input logic ep, input logic eh, input logic ew, input logic m, input logic r);
    logic [2:0] req;
    int top;
    req = pend_m | {ep, eh, ew};
    top = -1;
    for (int i = 0; i < 3; i++) if (req[i]) top = i;
    if (r || m) begin
      cur = -1;
      el = 0;
      pend_m = 3'b000;
    end else if (top >= 0 && top > cur) begin
      cur = top;
      el = 0;
      pend_m = req & ~(3'b001 << top);
    end else if (cur >= 0 && el + 1 == dur[cur] * TD) begin
      cur = -1;
      el = 0;
      pend_m = req;
    end else begin
      if (cur >= 0) el++;
      pend_m = req;
    end
  endtask
  task automatic step(input logic ep, input logic eh, input logic ew, input logic m, input logic r);
    @(negedge clk);
    check("busy", 32'(busy), cur >= 0 ? 32'd1 : 32'd0);
    check("grant", 32'(grant), cur >= 0 ? 32'(3'b001 << cur) : 32'd0);
    check("buzzer", 32'(buzzer), cur < 0 ? 32'd0 : ((el / hp[cur]) % 2 == 0) ? 32'd1 : 32'd0);
    if (busy) busy_cnt++;
    evt_point = ep;
    evt_hit = eh;
    evt_wall = ew;
    mute = m;
    reset = r;
    @(posedge clk);
    model(ep, eh, ew, m, r);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    hp[SRC_WALL] = 2;
    hp[SRC_HIT] = 3;
    hp[SRC_POINT] = 4;
    dur[SRC_WALL] = 1;
    dur[SRC_HIT] = 2;
    dur[SRC_POINT] = 3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    busy_cnt = 0;
    step(0, 1, 0, 0, 0);
    idle(25);
    check("hit_len", 32'(busy_cnt), 32'd20);
    busy_cnt = 0;
    step(0, 1, 1, 0, 0);
    idle(35);
    check("hit_wall_len", 32'(busy_cnt), 32'd30);
    busy_cnt = 0;
    step(0, 0, 1, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0);
    idle(40);
    check("preempt_len", 32'(busy_cnt), 32'd34);
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0);
    idle(55);
    busy_cnt = 0;
    step(0, 1, 0, 0, 0);
    idle(6);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(40);
    check("mute_len", 32'(busy_cnt), 32'd7);
    busy_cnt = 0;
    step(1, 0, 0, 0, 0);
    idle(4);
    step(0, 1, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("reset_len", 32'(busy_cnt), 32'd10);
    step(0, 1, 0, 0, 0);
    idle(5);
    step(0, 1, 0, 0, 0);
    idle(50);
    for (int c = 0; c < 4000; c++) begin
      if (mute_left == 0 && $urandom_range(199) == 0) mute_left = $urandom_range(6, 1);
      step($urandom_range(59) == 0, $urandom_range(29) == 0, $urandom_range(19) == 0,
           mute_left > 0, $urandom_range(799) == 0);
      if (mute_left > 0) mute_left--;
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Shares the single `buzzer` output between the game's three sound sources: point scored, paddle hit and wall bounce. Each source raises a one-cycle event; the block latches it, grants the buzzer by fixed priority and generates a square-wave tone of source-specific pitch and duration. It sits between the pong game logic and the top-level `buzzer` pin, in the `clk32mhz` domain (31.5 MHz).

## Interface
- `TICK_DIV`, 31500: `clk32mhz` cycles per 1 ms duration tick.
- `HP_POINT`, 63000: tone half-period in cycles for the point source (250 Hz).
- `HP_HIT`, 31500: tone half-period for the hit source (500 Hz).
- `HP_WALL`, 15750: tone half-period for the wall source (1 kHz).
- `DUR_POINT`, 250: point tone duration in ms ticks.
- `DUR_HIT`, 40: hit tone duration in ms ticks.
- `DUR_WALL`, 20: wall tone duration in ms ticks.
- `clk32mhz`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `evt_point`  in  1  one-cycle pulse when a point is scored.
- `evt_hit`  in  1  one-cycle pulse when the ball hits a paddle.
- `evt_wall`  in  1  one-cycle pulse when the ball bounces off a wall.
- `mute`  in  1  level; silences the block and discards all requests.
- `buzzer`  out  1  square-wave tone; 0 when idle.
- `busy`  out  1  tone in progress.
- `grant`  out  3  one-hot active source: [2] point, [1] hit, [0] wall; 0 when idle.

## Operation
- Priority, fixed: point > hit > wall.
- Request vector `req = pend | {evt_point, evt_hit, evt_wall}`. `pend` is a 3-bit register that holds events not yet served.
- States:
  - IDLE: if `req != 0` and `mute = 0`, grant the highest set bit and go to PLAY. The granted bit is cleared from `pend`; every other set bit of `req` is stored in `pend`.
  - PLAY: the half-period counter counts to HP−1 and then toggles `buzzer`. The tick counter counts to `TICK_DIV`−1 and then increments the ms counter.
    - When the ms counter reaches DUR on a tick wrap: go to IDLE, `buzzer` ← 0, `grant` ← 0.
    - Any `req` bit set during PLAY is ORed into `pend`.
- Preemption: in PLAY, a `req` bit of strictly higher priority than the current grant switches the grant at the next edge.
  - All counters reload and `buzzer` ← 1.
  - The preempted tone is dropped; it is not re-queued.
  - Equal or lower priority requests wait in `pend`.
- Re-trigger: an event from the currently granted source during PLAY sets its `pend` bit. That tone replays after the current one ends.
- Mute: while `mute = 1`, at every edge `pend` ← 0, events are ignored and the state is forced to IDLE. This includes aborting a tone in PLAY (`buzzer`, `busy`, `grant` ← 0 at the next edge).
- Reset: state IDLE, `pend` 0, all counters 0, `buzzer` 0, `busy` 0, `grant` 0. Reset in mid-tone aborts the tone and drops all pending requests.
- Widths:
  - Half-period counter: clog2 of the largest HP.
  - Tick counter: clog2(`TICK_DIV`).
  - ms counter: clog2(largest DUR + 1).
  - All counters are unsigned and wrap only by explicit reload.

## Timing
- Event high in cycle n with the block idle: `grant`, `busy` and `buzzer` are 1 from cycle n+1.
- `buzzer` is high for HP cycles, low for HP cycles, and repeats.
- Tone length: `busy` is high for exactly DUR×`TICK_DIV` cycles.
- After a tone ends, the block is IDLE for exactly one cycle before serving `pend`. Back-to-back tones therefore have a one-cycle gap with `busy` = 0.
- Simultaneous events in the same cycle: the highest is granted; the others land in `pend` and are served in priority order.
- Preempting event in cycle n: the new `grant` is visible from cycle n+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package: source index constants (`SRC_WALL`=0, `SRC_HIT`=1, `SRC_POINT`=2) and the one-hot grant encodings. These are reused by the game logic and the testbench.
- One sub-module, `tone_gen`: loads HP and DUR, owns the half-period, tick and ms counters, and drives `buzzer` and `done`.
- The arbiter FSM and `pend` stay in `sound_arbiter`.

## Test plan
All scenarios use `TICK_DIV`=10, HP_POINT/HIT/WALL = 4/3/2, DUR_POINT/HIT/WALL = 3/2/1.
- Single `evt_hit` pulse at cycle 5:
  - `grant`=3'b010 and `busy`=1 over cycles 6–25.
  - `buzzer` is 1 for cycles 6–8 and 0 for cycles 9–11, repeating.
  - `grant`=0 at cycle 26.
- `evt_wall` and `evt_hit` in the same cycle 0:
  - Hit plays over cycles 1–20.
  - Idle gap at cycle 21.
  - Wall plays over cycles 22–31 with `grant`=3'b001.
- `evt_wall` at cycle 0, then `evt_point` at cycle 4:
  - `grant`=3'b100 from cycle 5 and `buzzer` reset to 1.
  - Point tone runs for 30 cycles.
  - Wall is not replayed.
- `evt_point` at cycle 0, then `evt_hit` at cycle 3:
  - Point runs uninterrupted over cycles 1–30.
  - Hit is granted at cycle 32.
- `evt_hit` at cycle 0, then `mute` high in cycle 7:
  - `busy`, `buzzer` and `grant` are all 0 from cycle 8.
  - `evt_point` during mute produces nothing after `mute` falls.
- `evt_point` at cycle 0, then `reset` in cycle 10 with `evt_hit` pending:
  - All outputs are 0 from cycle 11.
  - No tone plays after `reset` is released.
